vga_sync_ctrl: RTL and testbench



---
 rtl/vga_sync_ctrl_if.sv | 25 ++
 rtl/vga_sync_ctrl.sv | 91 +++++++++
 tb/tb_vga_sync_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_sync_ctrl_if.sv
// Raster timing bundle from vga_sync_ctrl to pixel-generation logic.
// blank_n exists only when VGA_BLANK_N_EN is defined.
interface vga_sync_ctrl_if;
  logic        h_sync_out;
  logic        v_sync_out;
  logic [10:0] horizontal_position_out;
  logic [9:0]  vertical_position_out;
`ifdef VGA_BLANK_N_EN
  logic        blank_n;
`endif

  modport master (
    output h_sync_out, v_sync_out, horizontal_position_out, vertical_position_out
`ifdef VGA_BLANK_N_EN
    , blank_n
`endif
  );

  modport slave (
    input h_sync_out, v_sync_out, horizontal_position_out, vertical_position_out
`ifdef VGA_BLANK_N_EN
    , blank_n
`endif
  );
endinterface

// File: rtl/vga_sync_ctrl.sv
// VGA raster timing: chained h/v modulo counters with registered sync/blank decode aligned to position.
// Optional blank_n output enabled by macro VGA_BLANK_N_EN.
module vga_sync_ctrl #(
  parameter int H_VISIBLE  = 1024,
  parameter int H_FRONT    = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BACK     = 160,
  parameter int V_VISIBLE  = 768,
  parameter int V_FRONT    = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BACK     = 29,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic vga_clk_in,
  input  logic reset_in,
  vga_sync_ctrl_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_timing
      $error("vga_sync_ctrl: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end
  endgenerate

  // 12/11-bit constants so a window ending exactly at the counter range does not truncate.
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_LO = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] H_SYNC_HI = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_LO = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_HI = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [11:0] H_VIS     = 12'(H_VISIBLE);
  localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);

  logic [10:0] h_q, h_nxt;
  logic [9:0]  v_q, v_nxt;
  logic        hs_q, hs_nxt;
  logic        vs_q, vs_nxt;
  logic        h_wrap;
`ifdef VGA_BLANK_N_EN
  logic        blank_q, blank_nxt;
`endif

  // Decode from the next counter values so registered syncs line up with registered positions.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_nxt  = h_wrap ? 11'd0 : h_q + 11'd1;
    v_nxt  = v_q;
    if (h_wrap) begin
      v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
    hs_nxt = (({1'b0, h_nxt} >= H_SYNC_LO) && ({1'b0, h_nxt} < H_SYNC_HI)) ? H_SYNC_POL : ~H_SYNC_POL;
    vs_nxt = (({1'b0, v_nxt} >= V_SYNC_LO) && ({1'b0, v_nxt} < V_SYNC_HI)) ? V_SYNC_POL : ~V_SYNC_POL;
`ifdef VGA_BLANK_N_EN
    blank_nxt = ({1'b0, h_nxt} < H_VIS) && ({1'b0, v_nxt} < V_VIS);
`endif
  end

  always_ff @(posedge vga_clk_in) begin
    if (reset_in) begin
      h_q  <= 11'd0;
      v_q  <= 10'd0;
      hs_q <= ~H_SYNC_POL;
      vs_q <= ~V_SYNC_POL;
`ifdef VGA_BLANK_N_EN
      blank_q <= 1'b1;
`endif
    end else begin
      h_q  <= h_nxt;
      v_q  <= v_nxt;
      hs_q <= hs_nxt;
      vs_q <= vs_nxt;
`ifdef VGA_BLANK_N_EN
      blank_q <= blank_nxt;
`endif
    end
  end

  assign vga.h_sync_out              = hs_q;
  assign vga.v_sync_out              = vs_q;
  assign vga.horizontal_position_out = h_q;
  assign vga.vertical_position_out   = v_q;
`ifdef VGA_BLANK_N_EN
  assign vga.blank_n                 = blank_q;
`endif

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Scoreboard bench for vga_sync_ctrl using a reduced raster so whole frames fit in a short run.
module tb_vga_sync_ctrl;
  localparam int HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int VV = 12, VF = 2, VS = 3, VB = 4;
  localparam bit HPOL = 1'b0, VPOL = 1'b0;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_ctrl_if vif ();

  vga_sync_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL)
  ) dut (
    .vga_clk_in(clk),
    .reset_in  (rst),
    .vga       (vif.master)
  );

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
  } exp_t;

  exp_t   q[$];
  int     errors = 0;
  int     checks = 0;
  longint t = 0;

  // Beam position as a pure function of clocks elapsed since the last reset edge.
  function automatic exp_t model(longint tt);
    exp_t e;
    e.h  = int'(tt % HT);
    e.v  = int'((tt / HT) % VT);
    e.hs = (e.h >= HV + HF && e.h < HV + HF + HS) ? HPOL : !HPOL;
    e.vs = (e.v >= VV + VF && e.v < VV + VF + VS) ? VPOL : !VPOL;
    e.bl = (e.h < HV) && (e.v < VV);
    return e;
  endfunction

  task automatic drive(input bit r);
    rst = r;
    if (r) t = 0;
    else   t = t + 1;
    q.push_back(model(t));
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    int gh, gv;
    bit gbl;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        gh  = int'(vif.horizontal_position_out);
        gv  = int'(vif.vertical_position_out);
`ifdef VGA_BLANK_N_EN
        gbl = vif.blank_n;
`else
        gbl = e.bl;
`endif
        checks++;
        if (gh !== e.h || gv !== e.v || vif.h_sync_out !== e.hs ||
            vif.v_sync_out !== e.vs || gbl !== e.bl) begin
          errors++;
          $display("FAIL raster @%0t: got h=%0d v=%0d hs=%b vs=%b bl=%b, expected h=%0d v=%0d hs=%b vs=%b bl=%b",
                   $time, gh, gv, vif.h_sync_out, vif.v_sync_out, gbl,
                   e.h, e.v, e.hs, e.vs, e.bl);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    drive(1'b1);
    drive(1'b1);
    // Several uninterrupted frames cover every line and frame wrap and both sync windows.
    repeat (3 * FRAME) drive(1'b0);
    // Sparse random resets landing mid-line and mid-frame.
    repeat (3000) drive($urandom_range(0, 199) == 0);
    // Directed reset while the beam sits mid-frame.
    guard = 0;
    while ((t % FRAME) != longint'((VV / 2) * HT + HV / 2) && guard < FRAME + 1) begin
      drive(1'b0);
      guard++;
    end
    drive(1'b1);
    repeat (2 * HT) drive(1'b0);
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
